// File: rtl/ddr2_init_engine.sv
// DDR2 power-up initialization sequencer: walks the JEDEC init command list
// on the pad command bus, then raises a sticky ready flag.
`timescale 1ns/1ps
module ddr2_init_engine #(
   parameter int          T_CKE_LOW = 100,
   parameter int          T_XPR     = 20,
   parameter int          T_RP      = 3,
   parameter int          T_MRD     = 2,
   parameter int          T_RFC     = 26,
   parameter int          T_FINAL   = 200,
   parameter logic [12:0] MR_DLLRST = 13'h0542,
   parameter logic [12:0] MR_NORM   = 13'h0442,
   parameter logic [12:0] EMR1_BASE = 13'h0000,
   parameter logic [12:0] EMR1_OCD  = 13'h0380,
   parameter int          CW        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        initddr,
   output logic        cke,
   output logic        csbar,
   output logic        rasbar,
   output logic        casbar,
   output logic        webar,
   output logic [1:0]  ba,
   output logic [12:0] a,
   output logic        odt,
   output logic        busy,
   output logic        ready
);

   typedef enum logic [1:0] {IDLE, CKE_LOW, SEQ, DONE} state_t;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PREA = 4'b0010;
   localparam logic [3:0] CMD_MRS  = 4'b0000;
   localparam logic [3:0] CMD_REF  = 4'b0001;
   localparam logic [3:0] LAST_STEP = 4'd11;

   localparam logic [CW-1:0] L_CKE   = CW'(T_CKE_LOW - 1);
   localparam logic [CW-1:0] L_XPR   = CW'(T_XPR - 1);
   localparam logic [CW-1:0] L_RP    = CW'(T_RP - 1);
   localparam logic [CW-1:0] L_MRD   = CW'(T_MRD - 1);
   localparam logic [CW-1:0] L_RFC   = CW'(T_RFC - 1);
   localparam logic [CW-1:0] L_FINAL = CW'(T_FINAL - 1);

   state_t          state;
   logic [3:0]      step;
   logic [CW-1:0]   cnt;
   logic [3:0]      cmd;

   logic [3:0]      s_cmd;
   logic [1:0]      s_ba;
   logic [12:0]     s_a;
   logic [CW-1:0]   s_gap;

   assign {csbar, rasbar, casbar, webar} = cmd;

   // Command table: what step issues and how long to wait before the next one.
   always_comb begin
      s_cmd = CMD_NOP;
      s_ba  = 2'b00;
      s_a   = 13'h0000;
      s_gap = L_FINAL;
      case (step)
         4'd0:  begin s_cmd = CMD_PREA; s_a = 13'h0400; s_gap = L_RP; end
         4'd1:  begin s_cmd = CMD_MRS; s_ba = 2'b10; s_gap = L_MRD; end
         4'd2:  begin s_cmd = CMD_MRS; s_ba = 2'b11; s_gap = L_MRD; end
         4'd3:  begin s_cmd = CMD_MRS; s_ba = 2'b01; s_a = EMR1_BASE; s_gap = L_MRD; end
         4'd4:  begin s_cmd = CMD_MRS; s_a = MR_DLLRST; s_gap = L_MRD; end
         4'd5:  begin s_cmd = CMD_PREA; s_a = 13'h0400; s_gap = L_RP; end
         4'd6:  begin s_cmd = CMD_REF; s_gap = L_RFC; end
         4'd7:  begin s_cmd = CMD_REF; s_gap = L_RFC; end
         4'd8:  begin s_cmd = CMD_MRS; s_a = MR_NORM; s_gap = L_MRD; end
         4'd9:  begin s_cmd = CMD_MRS; s_ba = 2'b01; s_a = EMR1_OCD; s_gap = L_MRD; end
         4'd10: begin s_cmd = CMD_MRS; s_ba = 2'b01; s_a = EMR1_BASE; s_gap = L_FINAL; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         step  <= 4'd0;
         cnt   <= '0;
         cke   <= 1'b0;
         cmd   <= CMD_NOP;
         ba    <= 2'b00;
         a     <= 13'h0000;
         odt   <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b0;
      end else begin
         cmd <= CMD_NOP;
         ba  <= 2'b00;
         a   <= 13'h0000;
         odt <= 1'b0;
         case (state)
            IDLE: begin
               if (initddr) begin
                  state <= CKE_LOW;
                  busy  <= 1'b1;
                  cnt   <= L_CKE;
               end
            end
            // The edge that leaves CKE_LOW still drives cke low; SEQ raises it
            // one edge later, and the XPR wait is counted from that same edge.
            CKE_LOW: begin
               if (cnt == '0) begin
                  state <= SEQ;
                  step  <= 4'd0;
                  cnt   <= L_XPR;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SEQ: begin
               cke <= 1'b1;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (step == LAST_STEP) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end else begin
                  cmd  <= s_cmd;
                  ba   <= s_ba;
                  a    <= s_a;
                  cnt  <= s_gap;
                  step <= step + 1'b1;
               end
            end
            DONE: cke <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2_init_engine.sv
// Bench for ddr2_init_engine: default and back-to-back-timing instances,
// with an expected-command queue checked cycle by cycle against the pad bus.
`timescale 1ns/1ps
module tb_ddr2_init_engine;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] PREA = 4'b0010;
   localparam logic [3:0] MRS  = 4'b0000;
   localparam logic [3:0] REF  = 4'b0001;
   localparam int W = 35;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_a = 1'b0;
   logic init_b = 1'b0;
   logic sel = 1'b0;

   logic        a_cke, a_cs, a_ras, a_cas, a_we, a_odt, a_busy, a_ready;
   logic [1:0]  a_ba;
   logic [12:0] a_a;
   logic        b_cke, b_cs, b_ras, b_cas, b_we, b_odt, b_busy, b_ready;
   logic [1:0]  b_ba;
   logic [12:0] b_a;

   logic        m_cke, m_odt, m_busy, m_ready;
   logic [3:0]  m_cmd;
   logic [1:0]  m_ba;
   logic [12:0] m_a;

   logic [W-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   always #1 clk = ~clk;

   ddr2_init_engine dut (
      .clk(clk), .reset(rst), .initddr(init_a), .cke(a_cke), .csbar(a_cs),
      .rasbar(a_ras), .casbar(a_cas), .webar(a_we), .ba(a_ba), .a(a_a),
      .odt(a_odt), .busy(a_busy), .ready(a_ready)
   );

   ddr2_init_engine #(
      .T_CKE_LOW(10), .T_XPR(5), .T_RP(1), .T_MRD(1), .T_RFC(8), .T_FINAL(20)
   ) dut_fast (
      .clk(clk), .reset(rst), .initddr(init_b), .cke(b_cke), .csbar(b_cs),
      .rasbar(b_ras), .casbar(b_cas), .webar(b_we), .ba(b_ba), .a(b_a),
      .odt(b_odt), .busy(b_busy), .ready(b_ready)
   );

   always_comb begin
      m_cke = sel ? b_cke : a_cke;
      m_odt = sel ? b_odt : a_odt;
      m_busy = sel ? b_busy : a_busy;
      m_ready = sel ? b_ready : a_ready;
      m_cmd = sel ? {b_cs, b_ras, b_cas, b_we} : {a_cs, a_ras, a_cas, a_we};
      m_ba = sel ? b_ba : a_ba;
      m_a = sel ? b_a : a_a;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input int t, input logic [1:0] b,
                                         input logic [12:0] ad, input logic [3:0] c);
      logic [15:0] tc;
      tc = t[15:0];
      return {tc, b, ad, c};
   endfunction

   task automatic set_init(input logic v);
      if (sel) init_b = v;
      else init_a = v;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_status"}, {m_cke, m_busy, m_ready, m_odt}, 4'b0000);
      check({tag, "_bus"}, {m_cmd, m_ba, m_a}, {NOP, 2'b00, 13'h0000});
   endtask

   // Expected commands are queued from the timing parameters when the start
   // is driven, then popped as the DUT puts non-NOP commands on the bus.
   task automatic run_seq(input int tck, input int txpr, input int trp, input int tmrd,
                          input int trfc, input int tfin, input int abort_at,
                          input bit toggle);
      int t;
      int rdy;
      logic [W-1:0] got;
      logic [W-1:0] want;
      t = tck + txpr;
      exp_q.push_back(pack(t, 2'b00, 13'h0400, PREA));     t += trp;
      exp_q.push_back(pack(t, 2'b10, 13'h0000, MRS));      t += tmrd;
      exp_q.push_back(pack(t, 2'b11, 13'h0000, MRS));      t += tmrd;
      exp_q.push_back(pack(t, 2'b01, 13'h0000, MRS));      t += tmrd;
      exp_q.push_back(pack(t, 2'b00, 13'h0542, MRS));      t += tmrd;
      exp_q.push_back(pack(t, 2'b00, 13'h0400, PREA));     t += trp;
      exp_q.push_back(pack(t, 2'b00, 13'h0000, REF));      t += trfc;
      exp_q.push_back(pack(t, 2'b00, 13'h0000, REF));      t += trfc;
      exp_q.push_back(pack(t, 2'b00, 13'h0442, MRS));      t += tmrd;
      exp_q.push_back(pack(t, 2'b01, 13'h0380, MRS));      t += tmrd;
      exp_q.push_back(pack(t, 2'b01, 13'h0000, MRS));
      rdy = t + tfin;
      @(negedge clk);
      set_init(1'b1);
      @(posedge clk);
      for (int n = 0; n <= rdy + 10; n++) begin
         @(negedge clk);
         if (n == abort_at) return;
         if (!toggle && n == 1) set_init(1'b0);
         if (toggle && n == 50) set_init(1'b0);
         if (toggle && n == 200) set_init(1'b1);
         if (toggle && n == 300) set_init(1'b0);
         check("status", {m_cke, m_busy, m_ready, m_odt}, {n > tck, n < rdy, n >= rdy, 1'b0});
         if (exp_q.size() > 0 && int'(exp_q[0][W-1:W-16]) < n) begin
            check("missed_cmd", n, exp_q[0][W-1:W-16]);
            void'(exp_q.pop_front());
         end
         if (m_cmd == NOP) begin
            check("nop_addr", {m_ba, m_a}, 15'h0000);
         end else begin
            got = pack(n, m_ba, m_a, m_cmd);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("cmd", got, want);
         end
      end
      set_init(1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) set_init(1'b0);
         check("post_ready", {m_cke, m_busy, m_ready, m_odt, m_cmd, m_ba, m_a},
               {4'b1010, NOP, 2'b00, 13'h0000});
      end
      check("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_idle("in_reset");
      end
      rst = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         check_idle("idle");
      end

      run_seq(100, 20, 3, 2, 26, 200, -1, 1'b1);

      // Mid-sequence reset during the first REFRESH wait, then a clean restart.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_seq(100, 20, 3, 2, 26, 200, 150, 1'b0);
      rst = 1'b1;
      #0.2;
      check_idle("mid_reset");
      exp_q.delete();
      @(negedge clk);
      check_idle("mid_reset_hold");
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_reset");
      run_seq(100, 20, 3, 2, 26, 200, -1, 1'b0);

      sel = 1'b1;
      @(negedge clk);
      check_idle("fast_idle");
      run_seq(10, 5, 1, 1, 8, 20, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
